// File: rtl/id_issue_ctrl.sv
// Decode-stage sequencer: holds the IR feeding id_decoder, blocks issue on RAW hazards
// through a register scoreboard, and hands ops to id/ex. Optional perf counters: ID_ISSUE_PERF_EN.
module id_issue_ctrl #(
    parameter int                INST_W   = 32,
    parameter int                REG_AW   = 5,
    parameter logic [INST_W-1:0] NOP_INST = 32'h00000013
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_valid,
    input  logic [INST_W-1:0] if_inst,
    output logic              if_ready,
    output logic [INST_W-1:0] dec_inst,
    input  logic [REG_AW-1:0] dec_rs1,
    input  logic [REG_AW-1:0] dec_rs2,
    input  logic [REG_AW-1:0] dec_rd,
    input  logic              dec_use_rs2,
    input  logic              dec_wr,
    output logic              ex_valid,
    input  logic              ex_ready,
    input  logic              wb_valid,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              flush,
    output logic [31:0]       stall_cycles,
    output logic [31:0]       issue_count
);
    localparam int NREG = 1 << REG_AW;

    typedef enum logic [1:0] {IDLE, HELD, STALL} state_t;

    state_t            state;
    logic [INST_W-1:0] ir;
    logic [NREG-1:0]   sb, sb_nxt;
    logic              hazard, fire_ex, fire_if;

    // Hazard looks only at the registered scoreboard, so a same-cycle write-back
    // cannot release a dependent op until the following cycle.
    assign hazard   = sb[dec_rs1] | (dec_use_rs2 & sb[dec_rs2]);
    assign ex_valid = (state == HELD) & ~hazard & ~flush;
    assign fire_ex  = ex_valid & ex_ready;
    assign if_ready = rst & ~flush & ((state == IDLE) | fire_ex);
    assign fire_if  = if_valid & if_ready;
    assign dec_inst = ir;

    // Clear before set so a new producer of the same register keeps it busy.
    always_comb begin
        sb_nxt = sb;
        if (wb_valid)
            sb_nxt[wb_rd] = 1'b0;
        if (fire_ex && dec_wr && dec_rd != '0)
            sb_nxt[dec_rd] = 1'b1;
        sb_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            ir    <= NOP_INST;
            sb    <= '0;
        end else begin
            sb <= sb_nxt;
            if (flush) begin
                state <= IDLE;
                ir    <= NOP_INST;
            end else begin
                case (state)
                    IDLE: begin
                        if (fire_if) begin
                            ir    <= if_inst;
                            state <= HELD;
                        end
                    end
                    HELD: begin
                        if (hazard)
                            state <= STALL;
                        else if (fire_ex) begin
                            if (fire_if)
                                ir <= if_inst;
                            else
                                state <= IDLE;
                        end
                    end
                    STALL: begin
                        if (!hazard)
                            state <= HELD;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef ID_ISSUE_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles <= '0;
            issue_count  <= '0;
        end else begin
            if (state == STALL && stall_cycles != '1)
                stall_cycles <= stall_cycles + 32'd1;
            if (fire_ex && issue_count != '1)
                issue_count <= issue_count + 32'd1;
        end
    end
`else
    assign stall_cycles = '0;
    assign issue_count  = '0;
`endif

endmodule

// File: tb/tb_id_issue_ctrl.sv
// Randomized bench for id_issue_ctrl against a transaction-level model of the
// decode stage (held instruction, busy-register set, stall flag).
module tb_id_issue_ctrl;
    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_valid = 1'b0;
    logic [31:0] if_inst = '0;
    logic        if_ready;
    logic [31:0] dec_inst;
    logic [4:0]  dec_rs1, dec_rs2, dec_rd;
    logic        dec_use_rs2, dec_wr;
    logic        ex_valid;
    logic        ex_ready = 1'b0;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic        flush = 1'b0;
    logic [31:0] stall_cycles, issue_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Stand-in for id_decoder: RV32 field extraction from the IR.
    assign dec_rs1     = dec_inst[19:15];
    assign dec_rs2     = dec_inst[24:20];
    assign dec_rd      = dec_inst[11:7];
    assign dec_use_rs2 = (dec_inst[6:0] == 7'h33);
    assign dec_wr      = (dec_inst[6:0] == 7'h33) || (dec_inst[6:0] == 7'h13);

    id_issue_ctrl dut (
        .clk(clk), .rst(rst),
        .if_valid(if_valid), .if_inst(if_inst), .if_ready(if_ready),
        .dec_inst(dec_inst), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
        .dec_use_rs2(dec_use_rs2), .dec_wr(dec_wr),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
        .stall_cycles(stall_cycles), .issue_count(issue_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model
    bit          m_have, m_blk;
    logic [31:0] m_ir;
    bit   [31:0] m_busy;
    logic [31:0] m_stall, m_issue;
`ifdef ID_ISSUE_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    function automatic logic [31:0] rand_inst();
        logic [4:0] rs1, rs2, rd;
        int kind;
        rs1  = 5'($urandom_range(0, 7));
        rs2  = 5'($urandom_range(0, 7));
        rd   = 5'($urandom_range(0, 7));
        kind = $urandom_range(0, 9);
        if (kind < 5)      return {7'b0, rs2, rs1, 3'b000, rd, 7'h33};
        else if (kind < 9) return {7'b0, rs2, rs1, 3'b000, rd, 7'h13};
        else               return {7'b0, rs2, rs1, 3'b010, 5'b0, 7'h23};
    endfunction

    task automatic model_reset();
        m_have = 0; m_blk = 0; m_ir = NOP; m_busy = '0;
        m_stall = '0; m_issue = '0;
    endtask

    initial begin
        bit          haz, use2, wr, e_exv, e_ifr, f_ex, f_if, did_rst;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] zero32;
        zero32  = '0;
        did_rst = 0;
        model_reset();

        #12;
        chk("rst_ifr", {31'b0, if_ready}, 32'd0);
        chk("rst_exv", {31'b0, ex_valid}, 32'd0);
        chk("rst_ir", dec_inst, NOP);
        chk("rst_stall", stall_cycles, zero32);
        chk("rst_issue", issue_count, zero32);
        @(negedge clk);
        rst = 1'b1;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            rst = 1'b1;
            if (!did_rst && cyc >= 1500 && m_have && !m_blk) begin
                // Async reset while an instruction is held.
                did_rst = 1;
                flush = 1'b0; if_valid = 1'b0; wb_valid = 1'b1; wb_rd = 5'd1;
                #2 rst = 1'b0;
                #1;
                chk("mid_rst_exv", {31'b0, ex_valid}, 32'd0);
                chk("mid_rst_ifr", {31'b0, if_ready}, 32'd0);
                chk("mid_rst_ir", dec_inst, NOP);
                chk("mid_rst_stall", stall_cycles, zero32);
                chk("mid_rst_issue", issue_count, zero32);
                model_reset();
                wb_valid = 1'b0;
                continue;
            end

            if_valid = ($urandom_range(0, 9) < 7);
            if_inst  = rand_inst();
            ex_ready = ($urandom_range(0, 9) < 7);
            wb_valid = ($urandom_range(0, 9) < 3);
            wb_rd    = 5'($urandom_range(0, 7));
            flush    = ($urandom_range(0, 99) < 4);
            #1;

            rs1  = m_ir[19:15];
            rs2  = m_ir[24:20];
            rd   = m_ir[11:7];
            use2 = (m_ir[6:0] == 7'h33);
            wr   = (m_ir[6:0] == 7'h33) || (m_ir[6:0] == 7'h13);
            haz  = m_busy[rs1] || (use2 && m_busy[rs2]);
            e_exv = m_have && !m_blk && !haz && !flush;
            f_ex  = e_exv && ex_ready;
            e_ifr = !flush && (!m_have || f_ex);
            f_if  = if_valid && e_ifr;

            chk("ex_valid", {31'b0, ex_valid}, {31'b0, e_exv});
            chk("if_ready", {31'b0, if_ready}, {31'b0, e_ifr});
            chk("dec_inst", dec_inst, m_ir);
            chk("stall_cycles", stall_cycles, PERF ? m_stall : zero32);
            chk("issue_count", issue_count, PERF ? m_issue : zero32);

            @(posedge clk);
            if (m_blk && m_stall != 32'hFFFFFFFF) m_stall = m_stall + 1;
            if (f_ex && m_issue != 32'hFFFFFFFF)  m_issue = m_issue + 1;
            if (wb_valid) m_busy[wb_rd] = 1'b0;
            if (f_ex && wr && rd != 0) m_busy[rd] = 1'b1;
            m_busy[0] = 1'b0;
            if (flush) begin
                m_have = 0; m_blk = 0; m_ir = NOP;
            end else if (!m_have) begin
                if (f_if) begin m_ir = if_inst; m_have = 1; end
            end else if (m_blk) begin
                if (!haz) m_blk = 0;
            end else if (haz) begin
                m_blk = 1;
            end else if (f_ex) begin
                if (f_if) m_ir = if_inst;
                else      m_have = 0;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
